// File: rtl/i2c_apb_master.sv
// I2C slave front end that turns I2C register accesses into APB master transfers.
// The I2C bus is sampled on clk, so the block never stretches SCL.
// A write frame sets a 7-bit register pointer, and each following data byte
// becomes one APB write. A read frame returns APB read data on SDA; the next
// byte is fetched while the current one is being shifted out.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   scl_in, sda_in  : I2C bus inputs (asynchronous to clk)
//   sda_oe          : 1 pulls SDA low (open drain)
//   apb_*           : APB master interface (paddr/pwrite/pread/penable/pwdata out,
//                     prdata/pready/pslverr in)
//   busy            : an I2C frame is in progress
//   err             : sticky APB error/timeout flag, cleared by START
module i2c_apb_master #(
    parameter logic [6:0]  DEV_ADDR    = 7'h50,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [6:0] apb_paddr,
    output logic       apb_pwrite,
    output logic       apb_pread,
    output logic       apb_penable,
    output logic [7:0] apb_pwdata,
    input  logic [7:0] apb_prdata,
    input  logic       apb_pready,
    input  logic       apb_pslverr,
    output logic       busy,
    output logic       err
);
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RFETCH, RDATA, RACK
    } state_t;

    typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_ph_t;

    state_t        state;
    apb_ph_t       aph;
    logic          scl_s1, scl_s2, scl_h;
    logic          sda_s1, sda_s2, sda_h;
    logic [3:0]    cnt;
    logic [7:0]    sr;
    logic          rw;
    logic [6:0]    ptr;
    logic          req_v;
    logic          req_wr;
    logic [7:0]    req_data;
    logic [7:0]    rbuf;
    logic [TW-1:0] tcnt;

    logic scl_rise, scl_fall, start_det, stop_det;

    // Bus events, all derived from synchronized values
    assign scl_rise  = scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 & scl_h;
    assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            aph         <= APB_IDLE;
            scl_s1      <= 1'b1;
            scl_s2      <= 1'b1;
            scl_h       <= 1'b1;
            sda_s1      <= 1'b1;
            sda_s2      <= 1'b1;
            sda_h       <= 1'b1;
            cnt         <= '0;
            sr          <= '0;
            rw          <= 1'b0;
            ptr         <= '0;
            req_v       <= 1'b0;
            req_wr      <= 1'b0;
            req_data    <= '0;
            rbuf        <= '0;
            tcnt        <= '0;
            sda_oe      <= 1'b0;
            apb_paddr   <= '0;
            apb_pwrite  <= 1'b0;
            apb_pread   <= 1'b0;
            apb_penable <= 1'b0;
            apb_pwdata  <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;

            // APB engine: runs independently of the I2C state so a transfer
            // survives STOP/START and always completes or times out.
            case (aph)
                APB_IDLE: begin
                    if (req_v) begin
                        req_v      <= 1'b0;
                        apb_paddr  <= ptr;
                        apb_pwrite <= req_wr;
                        apb_pread  <= ~req_wr;
                        if (req_wr) apb_pwdata <= req_data;
                        aph        <= APB_SETUP;
                    end
                end
                APB_SETUP: begin
                    apb_penable <= 1'b1;
                    tcnt        <= '0;
                    aph         <= APB_ACCESS;
                end
                APB_ACCESS: begin
                    tcnt <= tcnt + TW'(1);
                    if (apb_pready || tcnt == TW'(TIMEOUT_CYC - 1)) begin
                        apb_penable <= 1'b0;
                        apb_pwrite  <= 1'b0;
                        apb_pread   <= 1'b0;
                        ptr         <= ptr + 7'd1;
                        aph         <= APB_IDLE;
                        if (!apb_pready || apb_pslverr) begin
                            err <= 1'b1;
                            if (apb_pread) rbuf <= 8'hFF;
                        end else if (apb_pread) begin
                            rbuf <= apb_prdata;
                        end
                    end
                end
                default: aph <= APB_IDLE;
            endcase

            // I2C frame sequencer
            case (state)
                IDLE: ;
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        sr  <= {sr[6:0], sda_s2};
                        cnt <= cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        cnt <= '0;
                        if (state == ADDR) begin
                            if (sr[7:1] == DEV_ADDR) begin
                                sda_oe <= 1'b1;
                                rw     <= sr[0];
                                state  <= ADDR_ACK;
                                // Fetch early so data is ready when the ACK clock ends
                                if (sr[0]) begin
                                    req_v  <= 1'b1;
                                    req_wr <= 1'b0;
                                end
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else if (state == PTR) begin
                            ptr    <= sr[6:0];
                            sda_oe <= 1'b1;
                            state  <= PTR_ACK;
                        end else begin
                            req_v    <= 1'b1;
                            req_wr   <= 1'b1;
                            req_data <= sr;
                            sda_oe   <= 1'b1;
                            state    <= WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (rw) begin
                        if (scl_rise) state <= RFETCH;
                    end else if (scl_fall) begin
                        sda_oe <= 1'b0;
                        state  <= PTR;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe <= 1'b0;
                        state  <= WDATA;
                    end
                end
                RFETCH: begin
                    // Load the fetched byte and prefetch the next one
                    if (scl_fall) begin
                        sr     <= rbuf;
                        sda_oe <= ~rbuf[7];
                        cnt    <= '0;
                        req_v  <= 1'b1;
                        req_wr <= 1'b0;
                        state  <= RDATA;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt <= cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            state  <= RACK;
                        end else begin
                            sr     <= {sr[6:0], 1'b0};
                            sda_oe <= ~sr[6];
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        cnt <= '0;
                        if (!sda_s2) begin
                            state <= RFETCH;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // START/STOP override every other event
            if (start_det) begin
                state  <= ADDR;
                cnt    <= '0;
                sda_oe <= 1'b0;
                busy   <= 1'b1;
                err    <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end
        end
    end
endmodule
